regfile_read_port: RTL

- Read-side controller for the 32-entry register file.
- Accepts read requests over a valid/ready handshake and drives the read address to the register array's combinational read mux.
- Captures the read data and returns it through a 2-entry response buffer with its own valid/ready handshake.
- Handles address-zero reads and, optionally, same-cycle write-to-read bypass. It is the consumer counterpart of the register file's write path.

---
 rtl/regfile_read_port.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/regfile_read_port.sv
// Read-side controller for the register file: accepts read requests, snapshots the
// read data, and returns it in order through a 2-entry response buffer.
// Optional macro RFRP_BYPASS_EN enables same-cycle write-to-read bypass.
module regfile_read_port #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] rsp_addr
);

    localparam int unsigned DEPTH = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] buf_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] buf_data_d [DEPTH];
    logic [ADDR_WIDTH-1:0] buf_addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] buf_addr_d [DEPTH];
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;

    logic                  push_c;
    logic                  pop_c;
    logic [DATA_WIDTH-1:0] cap_data_c;

    assign rf_rd_addr = req_addr;
    assign push_c     = req_valid && req_ready_q;
    assign pop_c      = rsp_valid_q && rsp_ready;

    // Value snapshotted for an accepted request; the zero register wins over bypass.
    always_comb begin
        cap_data_c = rf_rd_data;
`ifdef RFRP_BYPASS_EN
        if (wr_en && (wr_addr == req_addr)) begin
            cap_data_c = wr_data;
        end
`endif
        if ((ZERO_REG != 0) && (req_addr == '0)) begin
            cap_data_c = '0;
        end
    end

`ifndef RFRP_BYPASS_EN
    logic unused_wr_c;
    assign unused_wr_c = &{1'b0, wr_en, wr_addr, wr_data};
`endif

    // Occupancy, pointer and storage update.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        buf_data_d = buf_data_q;
        buf_addr_d = buf_addr_q;

        if (push_c) begin
            buf_data_d[wr_ptr_q] = cap_data_c;
            buf_addr_d[wr_ptr_q] = req_addr;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            ST_EMPTY: begin
                if (push_c) begin
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push_c && !pop_c) begin
                    state_d = ST_FULL;
                end else if (pop_c && !push_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop_c) begin
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Registered handshake and head outputs; head holds its last value when empty.
    always_comb begin
        req_ready_d = (state_d != ST_FULL);
        rsp_valid_d = (state_d != ST_EMPTY);
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        if (state_d != ST_EMPTY) begin
            rsp_data_d = buf_data_d[rd_ptr_d];
            rsp_addr_d = buf_addr_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_addr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_q[i] <= buf_data_d[i];
                buf_addr_q[i] <= buf_addr_d[i];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;

endmodule
